// File: rtl/ram_pkg.sv
// Shared parameters and FSM encoding for the RAM-backed FIFO controller.
// The top and the scrub counter take their parameter defaults from here.
package ram_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned AF_THRESH = 448;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_scrub_cnt.sv
// Address sweep used to zero the external RAM after reset.
// start parks the counter at 0; en advances it; done flags the final address.
module ram_scrub_cnt #(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned DEPTH  = ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] Last = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      addr <= '0;
    end else if (en) begin
      addr <= (addr == Last) ? '0 : addr + 1'b1;
    end
  end

  assign done = en && (addr == Last);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: port A writes, port B reads.
// After reset the RAM is scrubbed to zero before push/pop traffic is accepted.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W    = ram_pkg::DATA_W,
  parameter int unsigned ADDR_W    = ram_pkg::ADDR_W,
  parameter int unsigned DEPTH     = ram_pkg::DEPTH,
  parameter int unsigned AF_THRESH = ram_pkg::AF_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_address_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_wren_a,
  output logic              ram_rden_a,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_wren_b,
  output logic              ram_rden_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntAf   = (ADDR_W + 1)'(AF_THRESH);

  ram_pkg::state_e   state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] scrub_addr;
  logic              scrub_done;
  logic              in_run;
  logic              push_ok;
  logic              pop_ok;

  assign in_run      = (state == ram_pkg::StRun);
  assign full        = (count == CntFull);
  assign empty       = (count == '0);
  assign almost_full = (count >= CntAf);

  // Flags are judged on pre-edge occupancy; flush and rst veto any RAM access.
  assign push_ok = in_run && !rst && !flush && push && !full;
  assign pop_ok  = in_run && !rst && !flush && pop && !empty;

  // Counter is parked at 0 while running so a later INIT sweeps from 0.
  ram_scrub_cnt #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_scrub (
    .clk   (clk),
    .rst   (rst),
    .start (in_run),
    .en    (!in_run),
    .addr  (scrub_addr),
    .done  (scrub_done)
  );

  always_comb begin
    ram_wren_a    = 1'b0;
    ram_address_a = wr_ptr;
    ram_data_a    = '0;
    if (!rst) begin
      if (!in_run) begin
        ram_wren_a    = 1'b1;
        ram_address_a = scrub_addr;
      end else if (push_ok) begin
        ram_wren_a = 1'b1;
        ram_data_a = push_data;
      end
    end
  end

  assign ram_rden_a    = 1'b0;
  assign ram_wren_b    = 1'b0;
  assign ram_data_b    = '0;
  assign ram_rden_b    = pop_ok;
  assign ram_address_b = rd_ptr;

  // RAM read data lands the cycle after the read; only show it while valid.
  assign pop_data = pop_valid ? ram_q_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ram_pkg::StInit;
      init_done <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      unique case (state)
        ram_pkg::StInit: begin
          if (scrub_done) begin
            state     <= ram_pkg::StRun;
            init_done <= 1'b1;
          end
        end
        ram_pkg::StRun: begin
          if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
            if (push && full) overflow <= 1'b1;
            if (pop && empty) underflow <= 1'b1;
          end
        end
        default: state <= ram_pkg::StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue-based FIFO model,
// directed scenarios followed by randomized push/pop/flush traffic.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int AF    = 448;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_valid, full, empty, almost_full, overflow, underflow, init_done;
  logic [AW:0]   count;
  logic [AW-1:0] ram_address_a, ram_address_b;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_q_b;
  logic          ram_wren_a, ram_rden_a, ram_wren_b, ram_rden_b;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            wr_m, rd_m;
  bit            ov_m, un_m, pv_m;
  logic [DW-1:0] pd_m;

  ram_fifo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .pop_data      (pop_data),
    .pop_valid     (pop_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .init_done     (init_done),
    .ram_address_a (ram_address_a),
    .ram_data_a    (ram_data_a),
    .ram_wren_a    (ram_wren_a),
    .ram_rden_a    (ram_rden_a),
    .ram_address_b (ram_address_b),
    .ram_data_b    (ram_data_b),
    .ram_wren_b    (ram_wren_b),
    .ram_rden_b    (ram_rden_b),
    .ram_q_b       (ram_q_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_rden_b) ram_q_b <= mem[ram_address_b];
  end

  task automatic model_clear();
    mq.delete();
    wr_m = 0;
    rd_m = 0;
    ov_m = 0;
    un_m = 0;
    pv_m = 0;
  endtask

  // One RUN-mode clock: drive, check RAM ports before the edge, step model, check after.
  task automatic cycle(input bit p, input logic [DW-1:0] d, input bit o, input bit f);
    bit full_m, empty_m, ap, ao;
    int n;
    @(negedge clk);
    rst = 1'b0;
    push = p;
    push_data = d;
    pop = o;
    flush = f;
    n = mq.size();
    full_m = (n == DEPTH);
    empty_m = (n == 0);
    ap = p && !f && !full_m;
    ao = o && !f && !empty_m;
    #1;
    total++;
    if (ram_wren_a !== ap || (ap && (ram_address_a !== AW'(wr_m) || ram_data_a !== d))) begin
      bad++;
      $display("FAIL port_a: wren=%b addr=%0d data=%h, required wren=%b addr=%0d data=%h",
               ram_wren_a, ram_address_a, ram_data_a, ap, wr_m, d);
    end
    total++;
    if (ram_rden_b !== ao || (ao && ram_address_b !== AW'(rd_m))) begin
      bad++;
      $display("FAIL port_b: rden=%b addr=%0d, required rden=%b addr=%0d",
               ram_rden_b, ram_address_b, ao, rd_m);
    end
    total++;
    if (ram_rden_a !== 1'b0 || ram_wren_b !== 1'b0 || ram_data_b !== '0) begin
      bad++;
      $display("FAIL fixed_ports: rden_a=%b wren_b=%b data_b=%h, required 0 0 00",
               ram_rden_a, ram_wren_b, ram_data_b);
    end
    if (f) begin
      model_clear();
    end else begin
      pv_m = ao;
      if (ao) begin
        pd_m = mq.pop_front();
        rd_m = (rd_m + 1) % DEPTH;
      end
      if (ap) begin
        mq.push_back(d);
        wr_m = (wr_m + 1) % DEPTH;
      end
      if (p && full_m) ov_m = 1;
      if (o && empty_m) un_m = 1;
    end
    @(posedge clk);
    #1;
    n = mq.size();
    total++;
    if (count !== (AW + 1)'(n)) begin
      bad++;
      $display("FAIL count: got %0d, required %0d", count, n);
    end
    total++;
    if (empty !== (n == 0) || full !== (n == DEPTH) || almost_full !== (n >= AF)) begin
      bad++;
      $display("FAIL level_flags: empty=%b full=%b af=%b, required %b %b %b",
               empty, full, almost_full, n == 0, n == DEPTH, n >= AF);
    end
    total++;
    if (overflow !== ov_m || underflow !== un_m || init_done !== 1'b1) begin
      bad++;
      $display("FAIL sticky: ovf=%b udf=%b init_done=%b, required %b %b 1",
               overflow, underflow, init_done, ov_m, un_m);
    end
    total++;
    if (pop_valid !== pv_m || (pv_m && pop_data !== pd_m)) begin
      bad++;
      $display("FAIL pop_out: valid=%b data=%h, required valid=%b data=%h",
               pop_valid, pop_data, pv_m, pd_m);
    end
  endtask

  // Holds rst for one edge with push/pop requested; leaves rst high at posedge+1.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    push = 1'b1;
    pop = 1'b1;
    flush = 1'b0;
    push_data = 8'hAA;
    #1;
    total++;
    if (ram_wren_a !== 1'b0 || ram_rden_b !== 1'b0) begin
      bad++;
      $display("FAIL rst_enables: wren_a=%b rden_b=%b, required 0 0", ram_wren_a, ram_rden_b);
    end
    @(posedge clk);
    #1;
    total++;
    if (init_done !== 1'b0 || count !== '0 || empty !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0) begin
      bad++;
      $display("FAIL rst_state: init_done=%b count=%0d empty=%b full=%b af=%b, required 0 0 1 0 0",
               init_done, count, empty, full, almost_full);
    end
    total++;
    if (pop_valid !== 1'b0 || pop_data !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags: pop_valid=%b pop_data=%h ovf=%b udf=%b, required 0 00 0 0",
               pop_valid, pop_data, overflow, underflow);
    end
    model_clear();
  endtask

  // n scrub cycles with random (ignored) push/pop/flush requests.
  task automatic init_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      push = 1'($urandom_range(1));
      pop = 1'($urandom_range(1));
      flush = 1'($urandom_range(1));
      push_data = 8'($urandom);
      #1;
      total++;
      if (ram_wren_a !== 1'b1 || ram_address_a !== AW'(i) || ram_data_a !== '0 ||
          ram_rden_b !== 1'b0 || init_done !== 1'b0) begin
        bad++;
        $display("FAIL scrub: wren=%b addr=%0d data=%h rden_b=%b init_done=%b, required 1 %0d 00 0 0",
                 ram_wren_a, ram_address_a, ram_data_a, ram_rden_b, init_done, i);
      end
      @(posedge clk);
      #1;
    end
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_init_complete(input string tag);
    total++;
    if (init_done !== 1'b1 || empty !== 1'b1 || count !== '0 || overflow !== 1'b0 ||
        underflow !== 1'b0) begin
      bad++;
      $display("FAIL %s: init_done=%b empty=%b count=%0d ovf=%b udf=%b, required 1 1 0 0 0",
               tag, init_done, empty, count, overflow, underflow);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    init_sweep(DEPTH);
    check_init_complete("init_done_after_512");
  endtask

  task automatic test_mid_init_reset();
    apply_reset();
    init_sweep(200);
    apply_reset();
    init_sweep(DEPTH);
    check_init_complete("init_restart");
  endtask

  task automatic test_basic();
    cycle(1'b1, 8'h90, 1'b0, 1'b0);
    cycle(1'b1, 8'h50, 1'b0, 1'b0);
    total++;
    if (count !== 10'd2) begin
      bad++;
      $display("FAIL basic_count2: got %0d, required 2", count);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (pop_valid !== 1'b1 || pop_data !== 8'h90 || count !== 10'd1) begin
      bad++;
      $display("FAIL basic_pop1: valid=%b data=%h count=%0d, required 1 90 1",
               pop_valid, pop_data, count);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (pop_valid !== 1'b1 || pop_data !== 8'h50 || count !== 10'd0) begin
      bad++;
      $display("FAIL basic_pop2: valid=%b data=%h count=%0d, required 1 50 0",
               pop_valid, pop_data, count);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AF - 2 || i == AF - 1) begin
        total++;
        if (almost_full !== (i == AF - 1)) begin
          bad++;
          $display("FAIL af_edge: count=%0d af=%b, required %b", count, almost_full, i == AF - 1);
        end
      end
    end
    total++;
    if (full !== 1'b1 || count !== 10'd512) begin
      bad++;
      $display("FAIL full: full=%b count=%0d, required 1 512", full, count);
    end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1 || count !== 10'd512) begin
      bad++;
      $display("FAIL overflow: ovf=%b count=%0d, required 1 512", overflow, count);
    end
    cycle(1'b1, 8'hDD, 1'b1, 1'b0);
    total++;
    if (count !== 10'd511 || pop_data !== 8'h00 || pop_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_push_pop: count=%0d valid=%b data=%h, required 511 1 00",
               count, pop_valid, pop_data);
    end
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_empty();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (underflow !== 1'b1 || count !== '0) begin
      bad++;
      $display("FAIL underflow: udf=%b count=%0d, required 1 0", underflow, count);
    end
    cycle(1'b1, 8'h15, 1'b1, 1'b0);
    total++;
    if (count !== 10'd1 || pop_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_push_pop: count=%0d valid=%b, required 1 0", count, pop_valid);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    total++;
    if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        pop_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: count=%0d empty=%b ovf=%b udf=%b valid=%b, required 0 1 0 0 0",
               count, empty, overflow, underflow, pop_valid);
    end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int pp, po;
    for (int k = 0; k < 3000; k++) begin
      pp = ((k / 600) % 2 == 0) ? 90 : 25;
      po = ((k / 600) % 2 == 0) ? 20 : 80;
      cycle(1'($urandom_range(99) < pp), 8'($urandom), 1'($urandom_range(99) < po),
            1'($urandom_range(299) == 0));
    end
  endtask

  task automatic test_reset_from_run();
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b1, 1'b0);
    apply_reset();
    init_sweep(DEPTH);
    check_init_complete("reinit_from_run");
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, required finish before it");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mid_init_reset();
    test_basic();
    test_full();
    test_empty();
    test_flush();
    test_random();
    test_reset_from_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
